mlp_forward_engine: RTL
=======================

# mlp_forward_engine

Parametrised, time-multiplexed two-layer perceptron: N_HID ReLU hidden neurons over N_IN unsigned inputs, one linear output neuron, and a squared-error loss against a supplied target.
- Successor to the fixed two-hidden-neuron, hard-wired-weight datapath in the chip top.
- Weights live in a writable register file.
- A single shared multiply-accumulate unit walks all products sequentially under a start/valid handshake.
- Sits between the top-level pin mux and the future back-propagation controller.

## Interface
Parameters:
- N_IN, 4: inputs per hidden neuron (≥1)
- N_HID, 2: hidden neurons (≥1)
- XW, 4: input width, unsigned
- WW, 8: weight width, signed two's complement
- Derived widths:
  - SW = XW+WW+1+clog2(N_IN): hidden accumulator, signed
  - HW = SW−1: hidden output, unsigned
  - OW = HW+WW+1+clog2(N_HID): output, signed
  - LW = 2*(OW+1): loss, unsigned
- Derived depth: NWT = N_HID*N_IN+N_HID

Ports (one clock; reset is synchronous and active-high):
- clk_i  in  1  clock, rising edge
- rst_i  in  1  synchronous active-high reset
- wr_en_i  in  1  weight write strobe
- wr_addr_i  in  clog2(NWT)  weight index
  - hidden weight (h,i) at h*N_IN+i
  - output weight h at N_HID*N_IN+h
- wr_data_i  in  WW  weight value
- start_i  in  1  begin a forward pass
- x_i  in  N_IN*XW  inputs, x[i] at bits [i*XW +: XW], sampled on start
- target_i  in  OW  signed target, sampled on start
- busy_o  out  1  pass in progress
- valid_o  out  1  one-cycle pulse: y_o/loss_o updated
- y_o  out  OW  signed network output
- loss_o  out  LW  (y − target)²
- hidden_o  out  N_HID*HW  ReLU outputs, neuron h at [h*HW +: HW]

## Operation
- FSM states:
  - IDLE: waits for a pass.
  - HID: runs N_HID*N_IN cycles. Each cycle does acc += x[i]*w[h][i], i inner, h outer. On the last i, writes max(acc_final, 0) into hidden[h] and clears acc.
  - OUT: runs N_HID cycles. Each cycle does acc += hidden[h]*wo[h].
  - LOSS: one cycle. Latches y_o = acc and loss_o = (y − target)².
  - DONE: one cycle. valid_o = 1, then returns to IDLE.
- Transitions:
  - start_i in IDLE: latch x_i and target_i, clear acc, go to HID.
  - start_i in any other state is ignored; there is no queueing.
- Arithmetic:
  - Products are sign-extended to the accumulator width.
  - Widths are chosen so no overflow is possible, so there is no saturation and no wrap.
  - The ReLU of a negative or zero sum gives 0.
  - The difference for the loss is computed in OW+1 bits before squaring.
- Weight writes:
  - Accepted only in IDLE (busy_o = 0). Writes while busy are dropped.
  - Writes with wr_addr_i ≥ NWT are dropped.
  - wr_en_i and start_i on the same edge: the write commits and the pass uses the new value.
- Outputs:
  - y_o, loss_o and hidden_o hold their last values until the next pass overwrites them.
  - hidden_o updates progressively during HID.

## Timing
- Reset: rst_i high at an edge forces the following:
  - state returns to IDLE
  - all weights, hidden registers, acc, y_o and loss_o clear to 0
  - busy_o and valid_o go to 0
  - This applies mid-pass too; the pass is abandoned and no valid_o is emitted.
- Latency: start accepted at edge k gives valid_o high during cycle k+N_HID*N_IN+N_HID+2. With defaults that is k+12.
- busy_o is high from cycle k+1 through the valid_o cycle inclusive.
- The earliest next start is accepted on the edge ending the DONE cycle, giving a throughput of one pass per N_HID*N_IN+N_HID+3 cycles.
- There are no combinational paths from inputs to outputs.

## Structure
- Package mlp_pkg holds:
  - the state enum (IDLE, HID, OUT, LOSS, DONE)
  - clog2-based width functions for SW/HW/OW/LW/NWT
- Sub-module mac_unit holds the signed multiply-accumulate with clear and enable. It is shared by the HID and OUT phases via an operand mux.
- The top holds the FSM, the h/i counters, the weight register file, and the loss squarer.

## Test plan
- Defaults; weights n0 = n1 = {1,2,3,4}, wo = {5,8}; all x = 10; target = 0; start.
  - hidden = {100,100}, y_o = 1300, loss_o = 1690000.
  - valid_o exactly 12 cycles after start.
- Same setup, but n0 weights = {−1,−1,−1,−1}.
  - hidden[0] = 0 (ReLU), y_o = 800.
  - target = 900 gives loss_o = 10000.
- Write weight index 8 while busy, then rerun.
  - Result is unchanged.
  - A write to index NWT (10) is ignored.
- Assert rst_i 5 cycles into a pass.
  - No valid_o.
  - All outputs 0, and y_o = 0 on the next pass since the weights were cleared.
- Pulse start_i again while busy.
  - Ignored; only one valid_o.
  - A start on the DONE-exit edge is accepted.
- N_IN = 3, N_HID = 4, all weights +127, all x = 15.
  - hidden = 5715 each, y_o = 2903220.
  - Latency = 18 cycles, no overflow.

Source files
------------

// File: rtl/mlp_pkg.sv
// Shared types and width helpers for the two-layer perceptron forward engine.
package mlp_pkg;

  typedef enum logic [2:0] {
    IDLE,
    HID,
    OUT,
    LOSS,
    DONE
  } state_e;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    for (int k = 0; k < 32; k++) begin
      if ((1 << r) < n) r = r + 1;
    end
    return r;
  endfunction

  // Counter/address width that never collapses to zero bits.
  function automatic int cw(input int n);
    return (n > 1) ? clog2(n) : 1;
  endfunction

  function automatic int sw_w(input int n_in, input int xw, input int ww);
    return xw + ww + 1 + clog2(n_in);
  endfunction

  function automatic int hw_w(input int n_in, input int xw, input int ww);
    return sw_w(n_in, xw, ww) - 1;
  endfunction

  function automatic int ow_w(input int n_in, input int n_hid, input int xw, input int ww);
    return hw_w(n_in, xw, ww) + ww + 1 + clog2(n_hid);
  endfunction

  function automatic int lw_w(input int n_in, input int n_hid, input int xw, input int ww);
    return 2 * (ow_w(n_in, n_hid, xw, ww) + 1);
  endfunction

  function automatic int nwt_d(input int n_in, input int n_hid);
    return n_hid * n_in + n_hid;
  endfunction

endpackage

// File: rtl/mlp_forward_engine_mac.sv
// Signed multiply-accumulate shared by the hidden and output phases.
// Operand a is unsigned, operand b is signed; the product is sign-extended
// into the accumulator. nxt_o exposes the sum that the next enabled edge
// would store, so the caller can capture a final sum while clearing.
module mac_unit #(
  parameter int AW    = 14,
  parameter int BW    = 8,
  parameter int ACC_W = 24
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    clr_i,
  input  logic                    en_i,
  input  logic [AW-1:0]           a_i,
  input  logic signed [BW-1:0]    b_i,
  output logic signed [ACC_W-1:0] acc_o,
  output logic signed [ACC_W-1:0] nxt_o
);

  logic signed [AW+BW:0] prod;

  assign prod  = $signed({1'b0, a_i}) * b_i;
  assign nxt_o = acc_o + ACC_W'(prod);

  // Accumulator: clear has priority over accumulate.
  always_ff @(posedge clk_i) begin
    if (rst_i || clr_i) begin
      acc_o <= '0;
    end else if (en_i) begin
      acc_o <= nxt_o;
    end
  end

endmodule

// File: rtl/mlp_forward_engine.sv
// Time-multiplexed two-layer perceptron: N_HID ReLU hidden neurons, one
// linear output neuron and a squared-error loss, all products walked by a
// single MAC under a start/valid handshake.
module mlp_forward_engine
  import mlp_pkg::*;
#(
  parameter int N_IN   = 4,
  parameter int N_HID  = 2,
  parameter int XW     = 4,
  parameter int WW     = 8,
  localparam int HW    = hw_w(N_IN, XW, WW),
  localparam int OW    = ow_w(N_IN, N_HID, XW, WW),
  localparam int LW    = lw_w(N_IN, N_HID, XW, WW),
  localparam int NWT   = nwt_d(N_IN, N_HID),
  localparam int AWD   = cw(NWT)
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   wr_en_i,
  input  logic [AWD-1:0]         wr_addr_i,
  input  logic signed [WW-1:0]   wr_data_i,
  input  logic                   start_i,
  input  logic [N_IN*XW-1:0]     x_i,
  input  logic signed [OW-1:0]   target_i,
  output logic                   busy_o,
  output logic                   valid_o,
  output logic signed [OW-1:0]   y_o,
  output logic [LW-1:0]          loss_o,
  output logic [N_HID*HW-1:0]    hidden_o
);

  localparam int IW  = cw(N_IN);
  localparam int HCW = cw(N_HID);

  state_e                 state;
  logic [IW-1:0]          i_cnt;
  logic [HCW-1:0]         h_cnt;
  logic [N_IN*XW-1:0]     x_q;
  logic signed [OW-1:0]   tgt_q;
  logic signed [WW-1:0]   wt [NWT];

  logic                   start_ok;
  logic                   mac_clr;
  logic                   mac_en;
  logic [HW-1:0]          mac_a;
  logic signed [WW-1:0]   mac_b;
  logic [AWD-1:0]         wt_idx;
  logic signed [OW-1:0]   mac_acc;
  logic signed [OW-1:0]   mac_nxt;

  function automatic logic [HW-1:0] relu(input logic signed [OW-1:0] v);
    return (v > 0) ? HW'(v) : '0;
  endfunction

  // Difference is formed one bit wider than y so it cannot wrap, then squared.
  function automatic logic [LW-1:0] sq_err(input logic signed [OW-1:0] y,
                                           input logic signed [OW-1:0] t);
    logic signed [OW:0]   d;
    logic signed [LW-1:0] d_ext;
    d     = (OW+1)'(y) - (OW+1)'(t);
    d_ext = LW'(d);
    return $unsigned(d_ext * d_ext);
  endfunction

  assign start_ok = start_i && (state == IDLE || state == DONE);

  // Operand mux: inputs x hidden weights during HID, hidden x output weights during OUT.
  always_comb begin
    mac_a   = '0;
    mac_b   = '0;
    mac_en  = 1'b0;
    mac_clr = 1'b0;
    wt_idx  = '0;
    case (state)
      HID: begin
        wt_idx  = AWD'(h_cnt * N_IN + i_cnt);
        mac_a   = HW'(x_q[i_cnt*XW +: XW]);
        mac_b   = wt[wt_idx];
        mac_en  = 1'b1;
        mac_clr = (i_cnt == IW'(N_IN - 1));
      end
      OUT: begin
        wt_idx = AWD'(N_HID * N_IN + h_cnt);
        mac_a  = hidden_o[h_cnt*HW +: HW];
        mac_b  = wt[wt_idx];
        mac_en = 1'b1;
      end
      default: ;
    endcase
    if (start_ok) mac_clr = 1'b1;
  end

  mac_unit #(
    .AW    (HW),
    .BW    (WW),
    .ACC_W (OW)
  ) u_mac (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .clr_i (mac_clr),
    .en_i  (mac_en),
    .a_i   (mac_a),
    .b_i   (mac_b),
    .acc_o (mac_acc),
    .nxt_o (mac_nxt)
  );

  // Weight register file: writable only while idle, out-of-range addresses dropped.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int k = 0; k < NWT; k++) wt[k] <= '0;
    end else if (state == IDLE && wr_en_i && int'(wr_addr_i) < NWT) begin
      wt[wr_addr_i] <= wr_data_i;
    end
  end

  // Operand capture for the pass being launched.
  always_ff @(posedge clk_i) begin
    if (start_ok) begin
      x_q   <= x_i;
      tgt_q <= target_i;
    end
  end

  // Sequencer: walks i (inner) and h (outer), then the output neuron, loss and done.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state    <= IDLE;
      i_cnt    <= '0;
      h_cnt    <= '0;
      busy_o   <= 1'b0;
      valid_o  <= 1'b0;
      y_o      <= '0;
      loss_o   <= '0;
      hidden_o <= '0;
    end else begin
      valid_o <= 1'b0;
      case (state)
        IDLE: begin
          if (start_ok) begin
            state  <= HID;
            i_cnt  <= '0;
            h_cnt  <= '0;
            busy_o <= 1'b1;
          end
        end
        HID: begin
          if (i_cnt == IW'(N_IN - 1)) begin
            hidden_o[h_cnt*HW +: HW] <= relu(mac_nxt);
            i_cnt <= '0;
            if (h_cnt == HCW'(N_HID - 1)) begin
              h_cnt <= '0;
              state <= OUT;
            end else begin
              h_cnt <= h_cnt + 1'b1;
            end
          end else begin
            i_cnt <= i_cnt + 1'b1;
          end
        end
        OUT: begin
          if (h_cnt == HCW'(N_HID - 1)) begin
            h_cnt <= '0;
            state <= LOSS;
          end else begin
            h_cnt <= h_cnt + 1'b1;
          end
        end
        LOSS: begin
          y_o     <= mac_acc;
          loss_o  <= sq_err(mac_acc, tgt_q);
          valid_o <= 1'b1;
          state   <= DONE;
        end
        DONE: begin
          if (start_ok) begin
            state  <= HID;
            i_cnt  <= '0;
            h_cnt  <= '0;
          end else begin
            state  <= IDLE;
            busy_o <= 1'b0;
          end
        end
        default: begin
          state  <= IDLE;
          busy_o <= 1'b0;
        end
      endcase
    end
  end

endmodule
